cy_stream_rr_arbiter: RTL

Packet-aware round-robin arbiter that shares one registered valid/ready output stream among NREQ requesters. Each requester presents a valid/ready/last stream. A granted requester keeps the output until its last beat is accepted at the input side. The output stage is a registered skid stage: the internal o_ready is registered, and o_valid, o_data and o_last come straight from flops. The block sits in front of the shared downstream skid-buffered datapath.

---
 rtl/cy_stream_rr_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/cy_stream_rr_arbiter.sv
// Packet-aware round-robin arbiter feeding one registered valid/ready stream through a skid stage.
// Define CY_ARB_PKT_LOCK_EN to hold the grant until a last beat; otherwise arbitration is per beat.
module cy_stream_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NREQ-1:0]    i_valid,
  input  logic [NREQ*DW-1:0] i_data,
  input  logic [NREQ-1:0]    i_last,
  output logic [NREQ-1:0]    o_ready,
  output logic               o_valid,
  output logic [DW-1:0]      o_data,
  output logic               o_last,
  output logic [IW-1:0]      o_grant,
  output logic               o_busy,
  input  logic               i_ready
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   grant_q;
  logic            skid_valid_q;
  logic [DW-1:0]   skid_data_q;
  logic            skid_last_q;
  logic            out_valid_q;
  logic [DW-1:0]   out_data_q;
  logic            out_last_q;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic            accept;
  logic [DW-1:0]   in_data;
  logic            in_last;
  logic            pkt_end;

  // Rotating priority: first valid requester after ptr_q, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IW'((32'(ptr_q) + i) % NREQ);
      if (!win_found && i_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Only flop outputs feed o_ready, so it never depends on i_ready.
  always_comb begin
    o_ready = '0;
    if (state_q == StLocked && !skid_valid_q) begin
      o_ready[grant_q] = 1'b1;
    end
  end

  assign accept  = i_valid[grant_q] & o_ready[grant_q];
  assign in_data = i_data[32'(grant_q) * DW +: DW];
  assign in_last = i_last[grant_q];

`ifdef CY_ARB_PKT_LOCK_EN
  assign pkt_end = in_last;
`else
  assign pkt_end = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= StIdle;
      ptr_q        <= IW'(NREQ - 1);
      grant_q      <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q <= StLocked;
            grant_q <= win_idx;
            ptr_q   <= win_idx;
          end
        end
        StLocked: begin
          if (accept && pkt_end) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (!out_valid_q || i_ready) begin
        out_valid_q <= accept || skid_valid_q;
        if (skid_valid_q) begin
          out_data_q <= skid_data_q;
          out_last_q <= skid_last_q;
        end else if (accept) begin
          out_data_q <= in_data;
          out_last_q <= in_last;
        end
      end

      // Accept with skid full cannot happen: o_ready is low while skid_valid_q is set.
      if (skid_valid_q && i_ready) begin
        skid_valid_q <= 1'b0;
      end else if (accept && out_valid_q && !i_ready) begin
        skid_valid_q <= 1'b1;
        skid_data_q  <= in_data;
        skid_last_q  <= in_last;
      end
    end
  end

  assign o_valid = out_valid_q;
  assign o_data  = out_data_q;
  assign o_last  = out_last_q;
  assign o_grant = grant_q;
  assign o_busy  = (state_q == StLocked);

endmodule
